// File: rtl/ropuf_pkg.sv
// RO-PUF response sequencer shared types and defaults.
// State encoding, default geometry and small elaboration helpers.
package ropuf_pkg;

  localparam int N_BITS_D = 256;
  localparam int SEL_W_D  = 8;
  localparam int CNT_W_D  = 16;
  localparam int RESP_W   = N_BITS_D;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    COMPARE,
    SHIFT,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ropuf_phase_timer.sv
// Loadable down-counter timing the MEASURE and SETTLE phases.
// expire is high while the count sits at zero.
module ropuf_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ropuf_response_sequencer.sv
// Walks RO pairs, measures and compares counts, shifts response bits out.
// Define MAJORITY_VOTE_EN for three measurements per pair with a 2-of-3 vote.
module ropuf_response_sequencer
  import ropuf_pkg::*;
#(
  parameter int N_BITS        = N_BITS_D,
  parameter int SEL_W         = SEL_W_D,
  parameter int CNT_W         = CNT_W_D,
  parameter int MEAS_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic [SEL_W-1:0] ro_sel,
  output logic             ro_en,
  output logic             cnt_clr,
  output logic             sr_en,
  output logic             sr_s_in,
  output logic             busy,
  output logic             done
);

  localparam int TW =
    $clog2(max2(MEAS_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [TW-1:0] MEAS_LD =
    TW'(MEAS_CYCLES - 1);
  localparam logic [TW-1:0] SETL_LD =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(N_BITS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] ro_sel_q;
  logic             busy_q;
  logic             done_q;
  logic             t_load;
  logic [TW-1:0]    t_val;
  logic             t_exp;
  logic             cmp;
  logic             resp_bit;
  logic             last_rep;

  assign cmp = (cnt_a > cnt_b);

`ifdef MAJORITY_VOTE_EN
  logic [1:0] rep_q;
  logic [1:0] vote_q;

  assign last_rep = (rep_q == 2'd2);
  assign resp_bit = (vote_q >= 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q  <= '0;
      vote_q <= '0;
    end else if (state_q == COMPARE) begin
      rep_q  <= rep_q + 2'd1;
      vote_q <= vote_q + {1'b0, cmp};
    end else if (state_q == SHIFT ||
                 state_q == IDLE) begin
      rep_q  <= '0;
      vote_q <= '0;
    end
  end
`else
  logic bit_q;

  assign last_rep = 1'b1;
  assign resp_bit = bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else if (state_q == COMPARE) begin
      bit_q <= cmp;
    end
  end
`endif

  // One timer serves both phases; reload at phase entry.
  assign t_load = (state_q == CLEAR) ||
                  (state_q == MEASURE && t_exp);
  assign t_val  = (state_q == CLEAR) ? MEAS_LD : SETL_LD;

  ropuf_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .value  (t_val),
    .expire (t_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = MEASURE;
      MEASURE: if (t_exp) state_d = SETTLE;
      SETTLE:  if (t_exp) state_d = COMPARE;
      COMPARE: state_d = last_rep ? SHIFT : CLEAR;
      SHIFT:   state_d = (ro_sel_q == LAST) ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ro_sel_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        ro_sel_q <= '0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end
      if (state_q == SHIFT && ro_sel_q != LAST) begin
        ro_sel_q <= ro_sel_q + 1'b1;
      end
      if (state_q == DONE) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cnt_clr = 1'b0;
    ro_en   = 1'b0;
    sr_en   = 1'b0;
    sr_s_in = 1'b0;
    unique case (state_q)
      CLEAR:   cnt_clr = 1'b1;
      MEASURE: ro_en   = 1'b1;
      SHIFT: begin
        sr_en   = 1'b1;
        sr_s_in = resp_bit;
      end
      default: ;
    endcase
  end

  assign ro_sel = ro_sel_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ropuf_response_sequencer.sv
// Bench for ropuf_response_sequencer: directed steps with random counts.
// Honours MAJORITY_VOTE_EN for timing and vote expectations.
module tb_ropuf_response_sequencer;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CW = 16;
  localparam int M  = 8;
  localparam int S  = 2;
`ifdef MAJORITY_VOTE_EN
  localparam int REPS = 3;
  localparam int L    = 3 * (M + S + 2) + 1;
`else
  localparam int REPS = 1;
  localparam int L    = M + S + 3;
`endif
  localparam int NM = N * REPS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [SW-1:0] ro_sel;
  logic          ro_en;
  logic          cnt_clr;
  logic          sr_en;
  logic          sr_s_in;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ropuf_response_sequencer #(
    .N_BITS        (N),
    .SEL_W         (SW),
    .CNT_W         (CW),
    .MEAS_CYCLES   (M),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .ro_sel  (ro_sel),
    .ro_en   (ro_en),
    .cnt_clr (cnt_clr),
    .sr_en   (sr_en),
    .sr_s_in (sr_s_in),
    .busy    (busy),
    .done    (done)
  );

  logic [CW-1:0] ta [NM];
  logic [CW-1:0] tb_ [NM];
  int  clr_n = 0;
  int  ro_en_n = 0;
  int  ovl_n = 0;
  int  base = 0;
  int  kx;
  bit  got_q [$];
  int  sel_q [$];
  int  checks = 0;
  int  errors = 0;

  // Counts presented per measurement, indexed by clears since run start.
  always_comb begin
    kx = clr_n - base - 1;
    if (kx < 0 || kx >= NM) kx = 0;
    cnt_a = ta[kx];
    cnt_b = tb_[kx];
  end

  always @(negedge clk) begin
    if (cnt_clr) clr_n++;
    if (ro_en) ro_en_n++;
    if (ro_en && cnt_clr) ovl_n++;
    if (sr_en) begin
      got_q.push_back(sr_s_in);
      sel_q.push_back(int'(ro_sel));
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic bit exp_bit(input int p);
    int votes = 0;
    for (int r = 0; r < REPS; r++)
      if (ta[p*REPS+r] > tb_[p*REPS+r]) votes++;
    return (REPS == 1) ? (votes == 1) : (votes >= 2);
  endfunction

  task automatic rand_tables();
    for (int k = 0; k < NM; k++) begin
      ta[k] = CW'($urandom);
      if ($urandom_range(0, 3) == 0) tb_[k] = ta[k];
      else tb_[k] = CW'($urandom);
    end
  endtask

  task automatic fill(input int p, input int r,
                      input int a, input int b);
    ta[p*REPS+r]  = CW'(a);
    tb_[p*REPS+r] = CW'(b);
  endtask

  task automatic run_once(input bit poke);
    int cyc, gb, eb, ob;
    base = clr_n;
    gb = got_q.size();
    eb = ro_en_n;
    ob = ovl_n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    chk("busy_on", busy, 1);
    chk("done_clr", done, 0);
    chk("sel_zero", ro_sel, 0);
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 4) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      if (poke && cyc == N*L) start = 1'b1;
      if (poke && cyc == N*L+1) start = 1'b0;
    end
    chk("done_lat", cyc, N*L+1);
    chk("busy_off", busy, 0);
    chk("n_sr", got_q.size() - gb, N);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("bit%0d", p),
          (gb+p < got_q.size()) ? 64'(got_q[gb+p]) : 64'd9,
          exp_bit(p));
      chk($sformatf("sel%0d", p),
          (gb+p < sel_q.size()) ? 64'(sel_q[gb+p]) : 64'd9,
          p);
    end
    chk("ro_en_cyc", ro_en_n - eb, N*REPS*M);
    chk("en_clr_ovl", ovl_n - ob, 0);
  endtask

  initial begin
    int gb;
    for (int k = 0; k < NM; k++) begin
      ta[k] = '0;
      tb_[k] = '0;
    end
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", ro_sel, 0);
    chk("rst_en", ro_en, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_sren", sr_en, 0);
    chk("rst_sin", sr_s_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_clr", cnt_clr, 0);

    for (int p = 0; p < N; p++)
      for (int r = 0; r < REPS; r++)
        if (p % 2 == 0) fill(p, r, 100, 50);
        else fill(p, r, 50, 100);
    run_once(1'b0);

    for (int p = 0; p < N; p++)
      for (int r = 0; r < REPS; r++)
        fill(p, r, 'hFFFF, 'hFFFF);
    run_once(1'b0);
    for (int p = 0; p < N; p++)
      for (int r = 0; r < REPS; r++)
        fill(p, r, 'hFFFF, 0);
    run_once(1'b0);

    rand_tables();
    run_once(1'b1);
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    chk("ign_busy", busy, 0);
    chk("ign_en", ro_en, 0);
    rand_tables();
    run_once(1'b0);

    for (int i = 0; i < 3; i++) begin
      rand_tables();
      run_once(1'b0);
    end

    rand_tables();
    base = clr_n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2*L + 3) @(negedge clk);
    chk("pre_rst_en", ro_en, 1);
    chk("pre_rst_sel", ro_sel, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", ro_en, 0);
    chk("abort_sel", ro_sel, 0);
    chk("abort_done", done, 0);
    gb = got_q.size();
    repeat (2*L) @(negedge clk);
    chk("abort_nosr", got_q.size() - gb, 0);
    chk("abort_idle", busy, 0);
    rand_tables();
    run_once(1'b0);

`ifdef MAJORITY_VOTE_EN
    for (int p = 0; p < N; p++) begin
      if (p % 2 == 0) begin
        fill(p, 0, 200, 100);
        fill(p, 1, 300, 7);
        fill(p, 2, 5, 5);
      end else begin
        fill(p, 0, 10, 90);
        fill(p, 1, 91, 90);
        fill(p, 2, 4, 4);
      end
    end
    run_once(1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
